// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, byte-enable
// masks, FSM state type and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_CAPTURE,
        ST_RESP
    } lsu_state_e;

    // Legal funct3 for the access kind and natural alignment of the offset.
    function automatic logic access_ok(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] off);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for a store, steered to the addressed lanes.
    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'(BE_B << off);
            F3_H:    be = 4'(BE_H << off);
            default: be = BE_W;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the byte enables pick the right copy.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (funct3)
            F3_B:    lanes = {4{data[7:0]}};
            F3_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: shifts the addressed lane down and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_dout,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load_data
);

    logic [15:0] lane;

    // Select the addressed lane and apply the width/sign rule.
    always_comb begin
        lane = 16'(i_dout >> {i_offset, 3'b000});
        case (i_funct3)
            F3_B:    o_load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    o_load_data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   o_load_data = {24'h000000, lane[7:0]};
            F3_HU:   o_load_data = {16'h0000, lane[15:0]};
            default: o_load_data = i_dout;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory initiator: stores on BRAM port A, loads on port B with
// a fixed read latency, one transaction at a time.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BRAM_RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_done,
    output logic              o_misaligned,
    output logic [31:0]       o_load_data,
    output logic [ADDR_W-1:0] o_bram_wr_addr,
    output logic [31:0]       o_bram_din,
    output logic [3:0]        o_bram_we,
    output logic [ADDR_W-1:0] o_bram_rd_addr,
    input  logic [31:0]       i_bram_dout
);

    localparam logic [1:0] LAT_RELOAD = 2'(BRAM_RD_LAT - 1);

    lsu_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       din_q, din_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;

    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       aligned;
    logic              is_store;
    logic              is_load;
    logic              unused_addr_hi;

    // Upper address bits fall outside the memory, so accesses wrap.
    assign word_addr      = i_addr[ADDR_W+1:2];
    assign unused_addr_hi = ^i_addr[31:ADDR_W+2];
    assign is_store       = i_mem_write;
    assign is_load        = i_mem_read & ~i_mem_write;

    lsu_load_align u_align (
        .i_dout      (i_bram_dout),
        .i_offset    (off_q),
        .i_funct3    (funct3_q),
        .o_load_data (aligned)
    );

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        we_d        = '0;
        din_d       = din_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        mis_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    funct3_d = i_funct3;
                    off_d    = i_addr[1:0];
                    cnt_d    = LAT_RELOAD;
                    if (!is_store && !is_load) begin
                        state_d = ST_RESP;
                    end else if (!access_ok(is_store, i_funct3, i_addr[1:0])) begin
                        state_d = ST_RESP;
                        mis_d   = 1'b1;
                    end else if (is_store) begin
                        state_d   = ST_WRITE;
                        we_d      = store_be(i_funct3, i_addr[1:0]);
                        din_d     = store_lanes(i_funct3, i_store_data);
                        wr_addr_d = word_addr;
                    end else begin
                        state_d   = ST_READ_WAIT;
                        rd_addr_d = word_addr;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_CAPTURE: begin
                load_data_d = aligned;
                state_d     = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Completion is flagged in the single cycle spent in WRITE or RESP.
        done_d = (state_d == ST_WRITE) || (state_d == ST_RESP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            load_data_q <= '0;
            we_q        <= '0;
            din_q       <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            we_q        <= we_d;
            din_q       <= din_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
        end
    end

    assign o_ready        = (state_q == ST_IDLE);
    assign o_done         = done_q;
    assign o_misaligned   = mis_q;
    assign o_load_data    = load_data_q;
    assign o_bram_we      = we_q;
    assign o_bram_din     = din_q;
    assign o_bram_wr_addr = wr_addr_q;
    assign o_bram_rd_addr = rd_addr_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
CPU-side initiator for the RV32I data-memory BRAM. It accepts one load or store request per transaction from the MEM stage and drives the dual-port BRAM:
- Port A carries writes, with byte-enable and lane steering.
- Port B carries reads.

For loads it waits out the BRAM read latency, then shifts, sign-extends or zero-extends the data. It flags misaligned or illegal accesses and holds `o_ready` low while busy, so the pipeline stalls.

Parameters:
- ADDR_W, 10, BRAM word-address width; byte address bits [ADDR_W+1:2] select the word.
- BRAM_RD_LAT, 1, cycles from Port B address to valid `i_bram_dout`; range 1..3.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request valid; accepted when i_valid && o_ready.
- o_ready  out  1  high only in IDLE.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request; has priority over i_mem_read.
- i_funct3  in  3  RV32I width/sign code.
- i_addr  in  32  byte address (ALU result).
- i_store_data  in  32  rs2 value, right-aligned.
- o_done  out  1  one-cycle completion pulse.
- o_misaligned  out  1  error flag; valid only when o_done=1.
- o_load_data  out  32  formatted load result; held until the next load completes.
- o_bram_wr_addr  out  ADDR_W  Port A word address.
- o_bram_din  out  32  Port A data, lane-replicated.
- o_bram_we  out  4  Port A byte enables.
- o_bram_rd_addr  out  ADDR_W  Port B word address.
- i_bram_dout  in  32  Port B read data.

Behaviour:
- Reset (synchronous): state=IDLE, o_ready=1, o_done=0, o_misaligned=0, o_load_data=0, o_bram_we=0, both addresses 0, o_bram_din=0.
- Reset asserted mid-transaction: the transaction is dropped, with no o_done and no write. o_bram_we is 0 from the cycle after the reset edge.
- States: IDLE, WRITE, READ_WAIT, CAPTURE, RESP.
- Accept at cycle T: latch funct3, addr[1:0], word address, store data, and kind (store > load > none).
  - Error cases go to RESP with the error set and no BRAM access:
    - halfword with addr[0]=1;
    - word with addr[1:0]!=0;
    - illegal funct3 (store 011–111; load 011, 110, 111).
  - Neither read nor write: go to RESP with no error.
- Store: WRITE is T+1 and lasts one cycle.
  - o_bram_we: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111.
  - o_bram_din: SB = {4{d[7:0]}}; SH = {2{d[15:0]}}; SW = d.
  - o_done=1 in T+1, then return to IDLE; o_ready=1 at T+2.
  - o_bram_we is 0 in every other cycle.
- Load: READ_WAIT starts at T+1 and lasts BRAM_RD_LAT cycles, driving o_bram_rd_addr.
  - A down-counter reloaded with BRAM_RD_LAT−1 tracks the wait.
  - CAPTURE (T+1+BRAM_RD_LAT): lane = i_bram_dout >> (8*addr[1:0]).
    - LB: sign-extend [7:0]. LH: sign-extend [15:0]. LW: full word.
    - LBU: zero-extend [7:0]. LHU: zero-extend [15:0].
    - Registered into o_load_data.
  - RESP: o_done=1 at T+2+BRAM_RD_LAT, then IDLE.
- RESP for the error or no-op path: o_done=1 at T+1; o_misaligned=1 only for errors; o_load_data is unchanged.
- o_bram_rd_addr holds its last value outside loads. The BRAM may be read at any time, so this is harmless.
- Address bits above ADDR_W+1 are ignored, so the address wraps modulo the memory size.
- i_valid is ignored while o_ready=0. Request inputs are needed only in the accept cycle.
- Port A and Port B are never both active in the same cycle.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the state enum;
  - base byte masks BE_B=0001, BE_H=0011, BE_W=1111.
- One combinational sub-module, lsu_load_align (dout, offset, funct3 → load_data), reused by the bench as its reference model.

Test Plan:
- SW addr=0x010, data=0xDEADBEEF → T+1: we=1111, wr_addr=4, din=0xDEADBEEF, o_done=1; o_ready back at T+2.
- SB addr=0x013, data=0x000000A5 → we=1000, din=0xA5A5A5A5. Then LW addr=0x010 returns 0xA5ADBEEF with o_done at T+3 (BRAM_RD_LAT=1).
- LB/LBU addr=0x013 with word 0x80001234 → 0xFFFFFF80 / 0x00000080. LH/LHU addr=0x012 → 0xFFFF8000 / 0x00008000.
- LW addr=0x011 and SH addr=0x001 → o_done and o_misaligned at T+1, no we pulse, o_load_data unchanged. Load funct3=111 → same error response.
- i_mem_read=i_mem_write=1, SW addr=0x020 → store performed, no read. BRAM_RD_LAT=3 load → o_done exactly at T+5.
- i_rst asserted in READ_WAIT → next cycle: IDLE, o_ready=1, o_done never pulses, o_load_data=0. Back-to-back requests with i_valid held → each accepted only when o_ready=1.
